hub75_scan_driver: RTL and testbench

- Autonomous HUB75 LED-panel scan engine; replaces direct pin pass-through of R/A/clk/lat/OE.
- Fetches pixels from a framebuffer read port and serialises two row-halves on the RGB lines.
- Generates shift clock, latch, row address and output-enable.
- Sits between the framebuffer RAM and the panel connector pins.

---
 rtl/hub75_pkg.sv | 8 +
 rtl/hub75_sclk_gen.sv | 37 +++
 rtl/hub75_scan_driver.sv | 76 +++++++
 tb/tb_hub75_scan_driver.sv | 137 +++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types, constants and width helper for the HUB75 scan driver
package hub75_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;
  localparam int RGB_W = 6;
  function automatic int col_w(input int cols);
    return cols > 1 ? $clog2(cols) : 1;
  endfunction
endpackage

// File: rtl/hub75_sclk_gen.sv
// hub75_sclk_gen: CLK_DIV shift-clock divider with capture strobe and column count
// ports: clk, rst_n (async active-low), run (hold in reset when low),
//        sclk (low CLK_DIV cycles then high CLK_DIV cycles per column),
//        load (second low cycle of a column), done (last cycle of last column),
//        col (current column index)
module hub75_sclk_gen import hub75_pkg::*; #(
  parameter int COLS = 32,
  parameter int CLK_DIV = 2,
  localparam int CW = col_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          sclk,
  output logic          load,
  output logic          done,
  output logic [CW-1:0] col
);
  localparam int PW = $clog2(2 * CLK_DIV);
  logic [PW-1:0] ph;
  logic wrap;
  assign wrap = ph == PW'(2 * CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph  <= '0;
      col <= '0;
    end else if (!run) begin
      ph  <= '0;
      col <= '0;
    end else begin
      ph <= wrap ? '0 : ph + 1'b1;
      if (wrap) col <= col + 1'b1;
    end
  assign sclk = run && ph >= PW'(CLK_DIV);
  assign load = run && ph == PW'(1);
  assign done = run && wrap && &col;
endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: autonomous HUB75 scan engine (shift, blank, latch, display per row)
// ports: clk, rst_n (async active-low), enable, pix_addr {row,col} / pix_data (1-cycle read),
//        rgb, sclk, lat, oe_n, addr (panel pins), frame_done (pulse on last display cycle of frame)
// HUB75_BCM_EN: binary code modulation, BIT_DEPTH planes per row, plane b displayed ON_TIME<<b
module hub75_scan_driver import hub75_pkg::*; #(
  parameter int COLS = 32,
  parameter int ROW_ADDR_W = 4,
  parameter int CLK_DIV = 2,
  parameter int ON_TIME = 64,
  parameter int BIT_DEPTH = 4,
`ifdef HUB75_BCM_EN
  localparam int NPL = BIT_DEPTH,
`else
  localparam int NPL = 1 + 0 * BIT_DEPTH,
`endif
  localparam int CW = col_w(COLS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic [ROW_ADDR_W+CW-1:0] pix_addr,
  input  logic [RGB_W*NPL-1:0]     pix_data,
  output logic [RGB_W-1:0]         rgb,
  output logic                     sclk,
  output logic                     lat,
  output logic                     oe_n,
  output logic [ROW_ADDR_W-1:0]    addr,
  output logic                     frame_done
);
  localparam int PLW = NPL > 1 ? $clog2(NPL) : 1;
  localparam int TW = $clog2((ON_TIME << (NPL - 1)) + CLK_DIV) + 1;
  state_t state, nxt;
  logic [TW-1:0] cnt, on_len;
  logic [ROW_ADDR_W-1:0] row;
  logic [PLW-1:0] pl;
  logic [CW-1:0] col;
  logic load, done, last_pl, last_disp;
  hub75_sclk_gen #(.COLS(COLS), .CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .rst_n(rst_n), .run(state == SHIFT),
    .sclk(sclk), .load(load), .done(done), .col(col)
  );
  assign on_len = TW'(ON_TIME) << pl;
  assign last_pl = pl == PLW'(NPL - 1);
  assign last_disp = state == DISPLAY && cnt == on_len - 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE  ? (enable ? SHIFT : IDLE) :
          state == SHIFT ? (done ? BLANK : SHIFT) :
          state == BLANK ? LATCH :
          state == LATCH ? (cnt == TW'(CLK_DIV - 1) ? DISPLAY : LATCH) :
          last_disp ? (enable ? SHIFT : IDLE) : DISPLAY;
    lat = state == LATCH;
    oe_n = state != DISPLAY;
    frame_done = last_disp && last_pl && &row;
    pix_addr = {row, col};
  end
  // cnt restarts on every state change, so it measures time spent in LATCH/DISPLAY
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      row  <= '0;
      pl   <= '0;
      addr <= '0;
      rgb  <= '0;
    end else begin
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      if (load) rgb <= pix_data[RGB_W*pl +: RGB_W];
      if (state == BLANK) addr <= row;
      if (last_disp) begin
        pl <= last_pl ? '0 : pl + 1'b1;
        if (last_pl) row <= row + 1'b1;
      end
    end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: directed self-checking bench for hub75_scan_driver
module tb_hub75_scan_driver;
  localparam int COLS = 4, RAW = 2, CD = 2, ON = 8, BD = 2;
`ifdef HUB75_BCM_EN
  localparam int NPL = BD;
`else
  localparam int NPL = 1;
`endif
  logic clk = 0, rst_n = 0, enable = 0;
  logic [RAW+1:0] pix_addr;
  logic [6*NPL-1:0] pix_data;
  logic [5:0] rgb;
  logic sclk, lat, oe_n, frame_done;
  logic [RAW-1:0] addr;
  int total = 0, bad = 0;
  logic t_sclk [256], t_lat [256], t_oe [256], t_fd [256];
  logic [5:0] t_rgb [256];
  logic [RAW-1:0] t_addr [256];
  logic [RAW+1:0] t_pa [256];
  always #5 clk = ~clk;
  hub75_scan_driver #(.COLS(COLS), .ROW_ADDR_W(RAW), .CLK_DIV(CD), .ON_TIME(ON), .BIT_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_addr(pix_addr), .pix_data(pix_data),
    .rgb(rgb), .sclk(sclk), .lat(lat), .oe_n(oe_n), .addr(addr), .frame_done(frame_done)
  );
  always @(posedge clk)
    for (int b = 0; b < NPL; b++) pix_data[6*b +: 6] <= {6{pix_addr[0] ^ b[0]}};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic start();
    rst_n = 0;
    enable = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    enable = 1;
  endtask
  task automatic capture(input int n, input int drop);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      t_sclk[t] = sclk;
      t_lat[t] = lat;
      t_oe[t] = oe_n;
      t_fd[t] = frame_done;
      t_rgb[t] = rgb;
      t_addr[t] = addr;
      t_pa[t] = pix_addr;
      if (t == drop) enable = 0;
    end
  endtask
  function automatic int ones(input int sel, input int lo, input int hi);
    int n = 0;
    for (int t = lo; t < hi; t++)
      n += sel == 0 ? int'(t_sclk[t]) : sel == 1 ? int'(t_lat[t]) : sel == 2 ? int'(!t_oe[t]) : int'(t_fd[t]);
    return n;
  endfunction
  function automatic int rises(input int lo, input int hi);
    int n = 0;
    for (int t = lo; t < hi; t++) n += int'(t_sclk[t] && !t_sclk[t-1]);
    return n;
  endfunction
  initial begin
    logic [5:0] e;
    repeat (2) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_lat", lat, 0);
    chk("rst_oe", oe_n, 1);
    chk("rst_addr", addr, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_pa", pix_addr, 0);
    chk("rst_fd", frame_done, 0);
`ifdef HUB75_BCM_EN
    start();
    capture(62, -1);
    chk("bcm_lat", ones(1, 0, 62), 4);
    chk("bcm_oe0", ones(2, 0, 27), 8);
    chk("bcm_oe1", ones(2, 27, 62), 16);
    chk("bcm_rgb0", t_rgb[2], 6'h00);
    chk("bcm_rgb1", t_rgb[29], 6'h3F);
    chk("bcm_addr", t_addr[44], 0);
`else
    start();
    capture(216, -1);
    chk("lat_cnt_row0", ones(1, 0, 27), 2);
    chk("lat_first", t_lat[17], 1);
    chk("lat_pre", t_lat[16], 0);
    chk("rises_before_lat", rises(1, 17), 4);
    for (int c = 0; c < 4; c++) begin
      e = c[0] ? 6'h3F : 6'h00;
      chk("rgb_rise", t_rgb[4*c+2], e);
      chk("rgb_hold", t_rgb[4*c+3], e);
      chk("pa_row1", t_pa[27+4*c], 4 + c);
    end
    chk("oe_low_row0", ones(2, 0, 27), 8);
    chk("oe_first", t_oe[19], 0);
    chk("oe_pre", t_oe[18], 1);
    chk("oe_after", t_oe[27], 1);
    chk("next_shift", t_sclk[29], 1);
    for (int r = 0; r < 5; r++) chk("addr_step", t_addr[27*r+17], r % 4);
    chk("fd_count", ones(3, 0, 216), 2);
    chk("fd_at107", t_fd[107], 1);
    chk("fd_at215", t_fd[215], 1);
    chk("fd_oe", t_oe[107], 0);
    chk("fd_oe_next", t_oe[108], 1);
    for (int i = 0; i < 200 && !(oe_n == 0 && addr == 2); i++) @(negedge clk);
    chk("disp_wait", {oe_n, addr}, {1'b0, 2'd2});
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_oe", oe_n, 1);
    chk("arst_addr", addr, 0);
    chk("arst_rgb", rgb, 0);
    chk("arst_lat", lat, 0);
    chk("arst_sclk", sclk, 0);
    @(negedge clk);
    rst_n = 1;
    enable = 1;
    capture(30, -1);
    chk("restart_pa", t_pa[4], 1);
    chk("restart_lat", t_lat[17], 1);
    chk("restart_addr", t_addr[17], 0);
    start();
    capture(90, 32);
    chk("drop_lat", ones(1, 27, 90), 2);
    chk("drop_lat_at", t_lat[44], 1);
    chk("drop_oe", ones(2, 27, 90), 8);
    chk("drop_sclk", ones(0, 54, 90), 0);
    chk("drop_addr", t_addr[89], 1);
    chk("drop_oe_end", t_oe[89], 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
